ps2_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable-reporting)
//  to the mouse/keyboard over the open-collector clk/data pair, opposite direction to
//  the kbd_ms receiver. Sits between the I/O register decode and the ps2 pads; top level

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_sync.sv | 37 +++
 rtl/ps2_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and
// default timing constants (25 MHz system clock).
package ps2_pkg;

    localparam int FRAME_LEN = 11;  // start + 8 data + parity + stop/ack

    localparam int DEF_INHIBIT_CYC = 2500;
    localparam int DEF_SETUP_CYC   = 25;
    localparam int DEF_START_TMO   = 375000;
    localparam int DEF_XFER_TMO    = 50000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_CLK,
        ST_SHIFT,
        ST_WAIT_IDLE,
        ST_FAIL
    } tx_state_t;

    // Payload shifted out LSB first: eight data bits followed by odd parity.
    function automatic logic [8:0] frame_payload(input logic [7:0] b);
        return {~^b, b};
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > d) ? m : d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronized clock. Shared with the kbd_ms receiver.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic clk_fall
);

    logic clk_meta, data_meta, clk_prev;

    // NOTE: synchronizer flops reset to 1 because an idle open-collector bus
    // reads high; resetting to 0 would fake a falling edge after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            sync_clk  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            sync_clk  <= clk_meta;
            clk_prev  <= sync_clk;
            data_meta <= ps2_data_in;
            sync_data <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~sync_clk;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send
// and shifts one command byte out on device-generated clock edges.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int START_TMO   = DEF_START_TMO,
    parameter int XFER_TMO    = DEF_XFER_TMO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = $clog2(max4(INHIBIT_CYC, SETUP_CYC, START_TMO, XFER_TMO));
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYC - 1);
    localparam cnt_t SETUP_LAST   = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t START_LAST   = cnt_t'(START_TMO - 1);
    localparam cnt_t XFER_LAST    = cnt_t'(XFER_TMO - 1);

    localparam logic [3:0] PARITY_IDX = 4'(FRAME_LEN - 3);
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_LEN - 2);
    localparam logic [3:0] ACK_IDX    = 4'(FRAME_LEN - 1);

    tx_state_t  state, next_state;
    cnt_t       cnt, cnt_n;
    logic [3:0] bitcnt, bitcnt_n;
    logic [8:0] sr, sr_n;
    logic       clk_oe_q, clk_oe_n;
    logic       data_oe_q, data_oe_n;
    logic       err_q, err_n;
    logic       done_q, done_n;

    logic sync_clk, sync_data, clk_fall;

    ps2_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .sync_clk    (sync_clk),
        .sync_data   (sync_data),
        .clk_fall    (clk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            sr        <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_n;
            bitcnt    <= bitcnt_n;
            sr        <= sr_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            err_q     <= err_n;
            done_q    <= done_n;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_n      = cnt + cnt_t'(1);
        bitcnt_n   = bitcnt;
        sr_n       = sr;
        data_oe_n  = data_oe_q;
        err_n      = err_q;
        done_n     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_n     = '0;
                data_oe_n = 1'b0;
                if (start) begin
                    next_state = ST_INHIBIT;
                    sr_n       = frame_payload(din);
                    err_n      = 1'b0;
                end
            end

            ST_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    next_state = ST_REQ;
                    cnt_n      = '0;
                    data_oe_n  = 1'b1;  // start bit
                end
            end

            ST_REQ: begin
                if (cnt == SETUP_LAST) begin
                    next_state = ST_WAIT_CLK;
                    cnt_n      = '0;
                end
            end

            ST_WAIT_CLK: begin
                if (cnt == START_LAST) begin
                    next_state = ST_FAIL;
                    data_oe_n  = 1'b0;
                    err_n      = 1'b1;
                    done_n     = 1'b1;
                end else if (clk_fall) begin
                    // The device samples the start bit on this edge, so bit 0
                    // goes out now and this fall already counts as bit slot 0.
                    next_state = ST_SHIFT;
                    cnt_n      = '0;
                    bitcnt_n   = 4'd1;
                    data_oe_n  = ~sr[0];
                    sr_n       = {1'b0, sr[8:1]};
                end
            end

            ST_SHIFT: begin
                if (cnt == XFER_LAST) begin
                    next_state = ST_FAIL;
                    data_oe_n  = 1'b0;
                    err_n      = 1'b1;
                    done_n     = 1'b1;
                end else if (clk_fall) begin
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt <= PARITY_IDX) begin
                        data_oe_n = ~sr[0];
                        sr_n      = {1'b0, sr[8:1]};
                    end else if (bitcnt == STOP_IDX) begin
                        data_oe_n = 1'b0;
                    end else if (bitcnt == ACK_IDX) begin
                        if (!sync_data) begin
                            next_state = ST_WAIT_IDLE;
                        end else begin
                            next_state = ST_FAIL;
                            err_n      = 1'b1;
                            done_n     = 1'b1;
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (cnt == XFER_LAST) begin
                    next_state = ST_FAIL;
                    err_n      = 1'b1;
                    done_n     = 1'b1;
                end else if (sync_clk && sync_data) begin
                    next_state = ST_IDLE;
                    err_n      = 1'b0;
                    done_n     = 1'b1;
                end
            end

            ST_FAIL: begin
                next_state = ST_IDLE;
                data_oe_n  = 1'b0;
            end

            default: begin
                next_state = ST_IDLE;
                data_oe_n  = 1'b0;
            end
        endcase

        // Decoded from next_state so the pad enable is a clean flop output.
        clk_oe_n = (next_state == ST_INHIBIT) || (next_state == ST_REQ);
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: behavioural PS/2 device on wired-AND pads,
// frame expectations computed from the byte with plain arithmetic.
module tb_ps2_tx;

    localparam int INH   = 2500;
    localparam int SETUP = 25;
    localparam int START = 4000;
    localparam int XFER  = 3000;
    localparam int HALF  = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, err;
    logic       dev_clk, dev_data;

    int vectors     = 0;
    int miscompares = 0;

    int         done_total = 0;
    logic       err_at_done;
    logic [1:0] oe_at_done;

    ps2_tx #(
        .INHIBIT_CYC (INH),
        .SETUP_CYC   (SETUP),
        .START_TMO   (START),
        .XFER_TMO    (XFER)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .din         (din),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #20 clk = ~clk;

    // Open-collector bus: either side pulling low wins.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_total  <= done_total + 1;
            err_at_done <= err;
            oe_at_done  <= {ps2_clk_oe, ps2_data_oe};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits the device should see after falls 1..10: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic apply_start(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        din   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts inhibit and request cycles up to clock release; optionally pokes start.
    task automatic measure_phases(input int poke_at, input string tag);
        int inh, setup;
        inh   = 0;
        setup = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < INH + 100) begin
            inh++;
            if (inh == poke_at) begin
                start = 1'b1;
                din   = ~din;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        while (ps2_clk_oe && ps2_data_oe && setup < SETUP + 100) begin
            setup++;
            @(negedge clk);
        end
        check({tag, " inhibit_cycles"}, inh, INH);
        check({tag, " setup_cycles"}, setup, SETUP);
        check({tag, " start_to_release"}, 1 + inh + setup, INH + SETUP + 1);
        check({tag, " release_pads"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    task automatic dev_frame(input int n_falls, input bit ack_ok, input int poke_fall,
                             input int abort_fall, input string tag,
                             output logic [9:0] bits);
        bits = '0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11 && ack_ok) dev_data = 1'b0;
            @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            if (k == poke_fall) begin
                start = 1'b1;
                din   = ~din;
                @(negedge clk);
                start = 1'b0;
            end
            if (k == abort_fall) begin
                check({tag, " data_oe_before_reset"}, ps2_data_oe, 1'b1);
                rst_n = 1'b0;
                #1;
                check({tag, " oe_in_reset"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check({tag, " busy_in_reset"}, busy, 1'b0);
                @(negedge clk);
                rst_n   = 1'b1;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF / 2) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int base, input int budget);
        int cyc;
        cyc = 0;
        while (done_total == base && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic transact(input logic [7:0] b, input bit ack_ok, input int poke_inh,
                            input int poke_fall, input string tag);
        logic [9:0] bits;
        int base;
        base = done_total;
        apply_start(b);
        measure_phases(poke_inh, tag);
        dev_frame(11, ack_ok, poke_fall, 0, tag, bits);
        wait_done(base, XFER);
        repeat (50) @(negedge clk);
        check({tag, " frame_bits"}, bits, expected_frame(b));
        check({tag, " done_count"}, done_total - base, 1);
        check({tag, " err"}, err_at_done, !ack_ok);
        check({tag, " oe_at_done"}, oe_at_done, 2'b00);
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " err_held"}, err, !ack_ok);
    endtask

    initial begin
        logic [9:0] bits;
        int base, cyc;

        rst_n    = 1'b0;
        start    = 1'b0;
        din      = '0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset clk_oe", ps2_clk_oe, 1'b0);
        check("reset data_oe", ps2_data_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Enable-reporting command, acknowledged.
        transact(8'hF4, 1'b1, 0, 0, "f4_ack");

        // All-zero byte: parity bit must be 1 (line released after 9th fall).
        transact(8'h00, 1'b1, 0, 0, "zero_ack");

        // No device clock at all: start timeout.
        base = done_total;
        apply_start(8'hFF);
        measure_phases(0, "start_tmo");
        cyc = 0;
        while (done !== 1'b1 && cyc < START + 100) begin
            @(negedge clk);
            cyc++;
        end
        check("start_tmo cycles", cyc, START);
        check("start_tmo err", err, 1'b1);
        check("start_tmo oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        repeat (10) @(negedge clk);
        check("start_tmo done_count", done_total - base, 1);

        // Device never acknowledges.
        transact(8'h5A, 1'b0, 0, 0, "nack");

        // Start pulses during inhibit and shift are ignored.
        transact(8'hA5, 1'b1, 100, 4, "busy_start");

        // Asynchronous reset with bitcnt at 5 (bit 4 of 0x0F is 0, so data is pulled).
        base = done_total;
        apply_start(8'h0F);
        measure_phases(0, "mid_reset");
        dev_frame(11, 1'b1, 0, 5, "mid_reset", bits);
        repeat (200) @(negedge clk);
        check("mid_reset no_done", done_total - base, 0);
        check("mid_reset busy", busy, 1'b0);
        transact(8'hE6, 1'b1, 0, 0, "after_reset");

        // Randomised bytes, acknowledged.
        for (int i = 0; i < 4; i++) begin
            transact(8'($urandom_range(0, 255)), 1'b1, 0, 0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
